// File: rtl/load_unit_pkg.sv
// Shared pipeline definitions: memory opcodes, load-unit FSM encoding and
// helpers used by the load and store paths.
package load_unit_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } ld_state_e;

   function automatic logic is_load_op(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   // Bytes are always aligned; halfwords need an even address, words a multiple of 4.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((op == OP_LH) || (op == OP_LHU)) mis = off[0];
      else if (op == OP_LW)                mis = (off != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane selection and sign/zero extension of a loaded word.
module load_extract
   import load_unit_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      byte_lane = word[7:0];
      case (offset)
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         2'd3:    byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      half_lane = offset[1] ? word[31:16] : word[15:0];

      result = word;
      case (op)
         OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  result = {24'd0, byte_lane};
         OP_LH:   result = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  result = {16'd0, half_lane};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: one load in flight against a synchronous-read data
// memory, with alignment checking, flush and a held response toward WB.
module load_unit
   import load_unit_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [5:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [4:0]        req_rd,
   output logic              req_ready,
   input  logic              flush,
   output logic              mem_re,
   output logic [ADDR_W-3:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [4:0]        rsp_rd,
   output logic              rsp_misalign
);

   ld_state_e         state_q, state_d;
   logic [5:0]        op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-3:0] waddr_q, waddr_d;
   logic [4:0]        rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              mis_q, mis_d;
   logic              accept;
   logic [31:0]       extracted;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W];

   load_extract u_extract (
      .op     (op_q),
      .offset (off_q),
      .word   (mem_rdata),
      .result (extracted)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         off_q   <= '0;
         waddr_q <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         off_q   <= off_d;
         waddr_q <= waddr_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         mis_q   <= mis_d;
      end
   end

   // Flush wins over everything, including a request presented in the same cycle.
   assign accept = req_valid && (state_q == ST_IDLE) && !flush;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      off_d   = off_q;
      waddr_d = waddr_q;
      rd_d    = rd_q;
      data_d  = data_q;
      mis_d   = mis_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && is_load_op(req_op)) begin
                  op_d    = req_op;
                  off_d   = req_addr[1:0];
                  waddr_d = req_addr[ADDR_W-1:2];
                  rd_d    = req_rd;
                  mis_d   = is_misaligned(req_op, req_addr[1:0]);
                  data_d  = '0;
                  state_d = mis_d ? ST_RESP : ST_READ;
               end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
               data_d  = extracted;
               state_d = ST_RESP;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready    = (state_q == ST_IDLE);
      mem_re       = (state_q == ST_READ);
      rsp_valid    = (state_q == ST_RESP);
      mem_addr     = waddr_q;
      rsp_data     = data_q;
      rsp_rd       = rd_q;
      rsp_misalign = mis_q;
   end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: directed corner cases plus randomized loads
// checked against a plain-arithmetic reference model.
module tb_load_unit;
   import load_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [5:0]  req_op = '0;
   logic [31:0] req_addr = '0;
   logic [4:0]  req_rd = '0;
   logic        req_ready;
   logic        flush = 1'b0;
   logic        mem_re;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_misalign;

   load_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_rd       (req_rd),
      .req_ready    (req_ready),
      .flush        (flush),
      .mem_re       (mem_re),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_rd       (rsp_rd),
      .rsp_misalign (rsp_misalign)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] mem [0:255];
   always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mis;
      logic [7:0]  waddr;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   seen = 0;
   bit   rand_ready = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
   endfunction

   function automatic exp_t ref_load(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [4:0] rd, input int acc);
      exp_t   e;
      int     off;
      longint w;
      int     v;
      off     = int'(addr[1:0]);
      w       = longint'(mem[addr[9:2]]);
      e.rd    = rd;
      e.acc   = acc;
      e.waddr = addr[9:2];
      e.mis   = ((op == OP_LH || op == OP_LHU) && (off % 2 != 0)) || (op == OP_LW && off != 0);
      e.data  = '0;
      if (!e.mis) begin
         case (op)
            OP_LB: begin
               v = int'((w >> (8 * off)) % 256);
               if (v > 127) v -= 256;
               e.data = 32'(v);
            end
            OP_LBU: e.data = 32'((w >> (8 * off)) % 256);
            OP_LH: begin
               v = int'((w >> (8 * off)) % 65536);
               if (v > 32767) v -= 65536;
               e.data = 32'(v);
            end
            OP_LHU:  e.data = 32'((w >> (8 * off)) % 65536);
            default: e.data = 32'(w);
         endcase
      end
      return e;
   endfunction

   // Monitor: checks memory strobes and responses against the oldest expected load.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_re) begin
            if (sb.size() == 0) check("mem_re_unexpected", 32'(mem_re), 32'd0);
            else begin
               check("mem_addr", 32'(mem_addr), 32'(sb[0].waddr));
               check("mem_re_on_misaligned", 32'(sb[0].mis), 32'd0);
            end
         end
         if (rsp_valid) begin
            if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
               if (!seen) check("latency", 32'(cyc - sb[0].acc + 1), sb[0].mis ? 32'd1 : 32'd3);
               seen = 1;
               if (rsp_ready) begin
                  check("rsp_data", rsp_data, sb[0].data);
                  check("rsp_rd", 32'(rsp_rd), 32'(sb[0].rd));
                  check("rsp_misalign", 32'(rsp_misalign), 32'(sb[0].mis));
                  void'(sb.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd);
      int waited = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_rd    = rd;
      while (!req_ready && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!req_ready) begin
         check("issue_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
      end else begin
         if (is_legal(op)) sb.push_back(ref_load(op, addr, rd, cyc + 1));
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic directed(input string name, input logic [5:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] want, input logic want_mis);
      bit got = 0;
      issue(op, addr, rd);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      check({name, "_valid"}, 32'(got), 32'd1);
      if (got) begin
         check({name, "_data"}, rsp_data, want);
         check({name, "_mis"}, 32'(rsp_misalign), 32'(want_mis));
      end
      @(posedge clk);
      #1;
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [8];
      ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, 6'h22, 6'h00, 6'h3f};
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[8'h10] = 32'h8A7F_C3E1;

      @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_misalign", 32'(rsp_misalign), 32'd0);
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;

      directed("lb_41", OP_LB, 32'h41, 5'd1, 32'hFFFF_FFC3, 1'b0);
      directed("lbu_41", OP_LBU, 32'h41, 5'd2, 32'h0000_00C3, 1'b0);
      directed("lb_40", OP_LB, 32'h40, 5'd3, 32'hFFFF_FFE1, 1'b0);
      directed("lh_42", OP_LH, 32'h42, 5'd4, 32'hFFFF_8A7F, 1'b0);
      directed("lhu_40", OP_LHU, 32'h40, 5'd5, 32'h0000_C3E1, 1'b0);
      directed("lw_40", OP_LW, 32'h40, 5'd6, 32'h8A7F_C3E1, 1'b0);
      directed("lw_42", OP_LW, 32'h42, 5'd7, 32'h0, 1'b1);
      directed("lh_43", OP_LH, 32'h43, 5'd8, 32'h0, 1'b1);

      // Illegal opcode is swallowed without a memory access.
      issue(6'h22, 32'h40, 5'd9);
      check("illegal_ready", 32'(req_ready), 32'd1);
      check("illegal_mem_re", 32'(mem_re), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // Response held while WB stalls.
      rsp_ready = 1'b0;
      issue(OP_LHU, 32'h42, 5'd7);
      begin
         bit got = 0;
         for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
         end
         check("stall_valid", 32'(got), 32'd1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_data", rsp_data, 32'h0000_8A7F);
         check("stall_rd", 32'(rsp_rd), 32'd7);
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release_valid", 32'(rsp_valid), 32'd0);
      check("stall_release_ready", 32'(req_ready), 32'd1);

      // Flush in WAIT with a competing request, then flush in IDLE.
      issue(OP_LW, 32'h40, 5'd3);
      @(posedge clk);
      #1;
      flush = 1'b1;
      req_valid = 1'b1;
      req_op = OP_LW;
      req_addr = 32'h80;
      req_rd = 5'd4;
      @(posedge clk);
      #1;
      void'(sb.pop_front());
      seen = 0;
      check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
      check("flush_req_ready", 32'(req_ready), 32'd1);
      check("flush_mem_re", 32'(mem_re), 32'd0);
      @(posedge clk);
      #1;
      check("flush_idle_no_accept", 32'(req_ready), 32'd1);
      check("flush_idle_mem_re", 32'(mem_re), 32'd0);
      flush = 1'b0;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset pulsed while the read is outstanding.
      issue(OP_LW, 32'h44, 5'd9);
      rst = 1'b1;
      #1;
      void'(sb.pop_front());
      seen = 0;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_mem_re", 32'(mem_re), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_data", rsp_data, 32'd0);
      check("midrst_rd", 32'(rsp_rd), 32'd0);
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      directed("lw_after_rst", OP_LW, 32'h40, 5'd10, 32'h8A7F_C3E1, 1'b0);

      // Randomized traffic with random WB back-pressure.
      rand_ready = 1;
      for (int n = 0; n < 120; n++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 7) == 0) ? ops[$urandom_range(5, 7)] : ops[$urandom_range(0, 4)];
         issue(op, $urandom, 5'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_ready = 0;
      rsp_ready = 1'b1;
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
